// File: rtl/insn_encoder_if.sv
// Request/response bundle for insn_encoder: field-level request handshake in,
// encoded instruction word handshake out, plus the illegal-request pulse.
interface insn_encoder_if;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [3:0]  i_req_kind;
  logic [2:0]  i_funct3;
  logic        i_funct7_5;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        o_insn_vld;
  logic        i_insn_rdy;
  logic [31:0] o_insn;
  logic [31:0] o_pc;
  logic        o_err;

  modport master (
    output i_req_vld, i_req_kind, i_funct3, i_funct7_5, i_rd, i_rs1, i_rs2, i_imm, i_insn_rdy,
    input  o_req_rdy, o_insn_vld, o_insn, o_pc, o_err
  );

  modport slave (
    input  i_req_vld, i_req_kind, i_funct3, i_funct7_5, i_rd, i_rs1, i_rs2, i_imm, i_insn_rdy,
    output o_req_rdy, o_insn_vld, o_insn, o_pc, o_err
  );
endinterface

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: turns field-level requests into 32-bit words with
// word addresses; expands the li pseudo-op into lui/addi when it needs two words.
module insn_encoder #(
  parameter logic [31:0] BASE_PC = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_flush,
  insn_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_FULL_LI = 2'd2
  } state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  state_e      state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] addi_q, addi_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  logic [31:0] enc_word_s;
  logic [31:0] enc_addi_s;
  logic        enc_two_s;
  logic        enc_illegal_s;
  logic [19:0] li_hi_s;
  logic        li_short_s;
  logic        req_rdy_s;
  logic        req_acc_s;
  logic        out_hs_s;
  logic        load_s;

  wire [2:0]  f3   = bus.i_funct3;
  wire        f75  = bus.i_funct7_5;
  wire [31:0] imm  = bus.i_imm;

  // li fits a single addi when bits 31..11 are a pure sign extension
  assign li_short_s = (imm[31:11] == 21'h00_0000) || (imm[31:11] == 21'h1F_FFFF);
  assign li_hi_s    = imm[31:12] + {19'd0, imm[11]};

  assign req_rdy_s = !i_flush && ((state_q == ST_EMPTY) ||
                                  ((state_q == ST_FULL) && bus.i_insn_rdy));
  assign req_acc_s = bus.i_req_vld && req_rdy_s;
  assign out_hs_s  = (state_q != ST_EMPTY) && bus.i_insn_rdy;
  assign load_s    = req_acc_s && !enc_illegal_s;

  // Field-level request -> instruction word(s) plus legality
  always_comb begin
    enc_word_s    = 32'h0000_0000;
    enc_two_s     = 1'b0;
    enc_illegal_s = 1'b0;
    enc_addi_s    = {imm[11:0], bus.i_rd, 3'b000, bus.i_rd, OP_I};
    case (bus.i_req_kind)
      4'd0: begin
        enc_illegal_s = f75 && (f3 != 3'b000) && (f3 != 3'b101);
        enc_word_s    = {1'b0, f75, 5'b00000, bus.i_rs2, bus.i_rs1, f3, bus.i_rd, OP_R};
      end
      4'd1: begin
        enc_illegal_s = (f3 == 3'b001) && f75;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          enc_word_s = {1'b0, f75, 5'b00000, imm[4:0], bus.i_rs1, f3, bus.i_rd, OP_I};
        end else begin
          enc_word_s = {imm[11:0], bus.i_rs1, f3, bus.i_rd, OP_I};
        end
      end
      4'd2: begin
        enc_illegal_s = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        enc_word_s    = {imm[11:0], bus.i_rs1, f3, bus.i_rd, OP_LOAD};
      end
      4'd3: begin
        enc_illegal_s = (f3 >= 3'b011);
        enc_word_s    = {imm[11:5], bus.i_rs2, bus.i_rs1, f3, imm[4:0], OP_STORE};
      end
      4'd4: begin
        enc_illegal_s = (f3 == 3'b010) || (f3 == 3'b011) || imm[0];
        enc_word_s    = {imm[12], imm[10:5], bus.i_rs2, bus.i_rs1, f3,
                         imm[4:1], imm[11], OP_BRANCH};
      end
      4'd5: enc_word_s = {imm[31:12], bus.i_rd, OP_LUI};
      4'd6: enc_word_s = {imm[31:12], bus.i_rd, OP_AUIPC};
      4'd7: begin
        enc_illegal_s = imm[0];
        enc_word_s    = {imm[20], imm[10:1], imm[11], imm[19:12], bus.i_rd, OP_JAL};
      end
      4'd8: enc_word_s = {imm[11:0], bus.i_rs1, 3'b000, bus.i_rd, OP_JALR};
      4'd9: begin
        if (li_short_s) begin
          enc_word_s = {imm[11:0], 5'd0, 3'b000, bus.i_rd, OP_I};
        end else begin
          enc_word_s = {li_hi_s, bus.i_rd, OP_LUI};
          enc_two_s  = (imm[11:0] != 12'h000);
        end
      end
      default: enc_illegal_s = 1'b1;
    endcase
  end

  // Output-holding FSM: next state, held word, pending addi, address, error pulse
  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    addi_d  = addi_q;
    pc_d    = pc_q;
    err_d   = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
      insn_d  = 32'h0000_0000;
      addi_d  = 32'h0000_0000;
      pc_d    = BASE_PC;
    end else begin
      err_d = req_acc_s && enc_illegal_s;
      if (out_hs_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      case (state_q)
        ST_EMPTY: begin
          if (load_s) begin
            insn_d  = enc_word_s;
            addi_d  = enc_addi_s;
            state_d = enc_two_s ? ST_FULL_LI : ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (!bus.i_insn_rdy) begin
            state_d = ST_FULL;
          end else if (load_s) begin
            insn_d  = enc_word_s;
            addi_d  = enc_addi_s;
            state_d = enc_two_s ? ST_FULL_LI : ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL_LI: begin
          if (bus.i_insn_rdy) begin
            insn_d  = addi_q;
            state_d = ST_FULL;
          end else begin
            state_d = ST_FULL_LI;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_EMPTY;
      insn_q  <= 32'h0000_0000;
      addi_q  <= 32'h0000_0000;
      pc_q    <= BASE_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      addi_q  <= addi_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_req_rdy  = req_rdy_s;
  assign bus.o_insn_vld = (state_q != ST_EMPTY);
  assign bus.o_insn     = insn_q;
  assign bus.o_pc       = pc_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: a field-level encoding model feeds an
// expected-word queue that is checked against every held output word.
module tb_insn_encoder;
  logic clk;
  logic rst_n;
  logic flush;

  insn_encoder_if bus ();

  insn_encoder #(.BASE_PC(32'h0000_0000)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  int          checks;
  int          failures;
  int          exp_err;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Encoding model built from field positions with plain shifts and masks
  function automatic void model_req(input logic [3:0] k, input logic [2:0] f3, input logic f75,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
      output logic ill, output int n, output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] rdf, f3f, rs1f, rs2f, lo, hi, f7f;
    int sv;
    rdf  = 32'(rd) << 7;
    f3f  = 32'(f3) << 12;
    rs1f = 32'(rs1) << 15;
    rs2f = 32'(rs2) << 20;
    f7f  = 32'(f75) << 30;
    lo   = imm & 32'h0000_0FFF;
    ill  = 1'b0;
    n    = 1;
    w0   = 32'd0;
    w1   = 32'd0;
    case (k)
      4'd0: begin
        ill = f75 && (f3 != 3'd0) && (f3 != 3'd5);
        w0  = f7f | rs2f | rs1f | f3f | rdf | 32'h33;
      end
      4'd1: begin
        ill = (f3 == 3'd1) && f75;
        if ((f3 == 3'd1) || (f3 == 3'd5)) w0 = f7f | ((imm & 32'h1F) << 20) | rs1f | f3f | rdf | 32'h13;
        else w0 = (lo << 20) | rs1f | f3f | rdf | 32'h13;
      end
      4'd2: begin
        ill = (f3 == 3'd3) || (f3 >= 3'd6);
        w0  = (lo << 20) | rs1f | f3f | rdf | 32'h03;
      end
      4'd3: begin
        ill = (f3 >= 3'd3);
        w0  = (((imm >> 5) & 32'h7F) << 25) | rs2f | rs1f | f3f | ((imm & 32'h1F) << 7) | 32'h23;
      end
      4'd4: begin
        ill = (f3 == 3'd2) || (f3 == 3'd3) || imm[0];
        w0  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rs2f | rs1f | f3f |
              (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      4'd5: w0 = (imm & 32'hFFFF_F000) | rdf | 32'h37;
      4'd6: w0 = (imm & 32'hFFFF_F000) | rdf | 32'h17;
      4'd7: begin
        ill = imm[0];
        w0  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000) | rdf | 32'h6F;
      end
      4'd8: w0 = (lo << 20) | rs1f | rdf | 32'h67;
      4'd9: begin
        sv = $signed(imm);
        if (sv >= -2048 && sv <= 2047) begin
          w0 = (lo << 20) | rdf | 32'h13;
        end else begin
          hi = (imm + 32'h800) & 32'hFFFF_F000;
          w0 = hi | rdf | 32'h37;
          if (lo != 32'd0) begin
            n  = 2;
            w1 = (lo << 20) | (32'(rd) << 15) | rdf | 32'h13;
          end
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic pin(input string name, input logic [3:0] k, input logic [31:0] imm,
                     input logic [4:0] rd, input logic f75, input logic [31:0] e0, input logic [31:0] e1);
    logic ill; int n; logic [31:0] w0, w1;
    model_req(k, 3'd0, f75, rd, 5'd1, 5'd2, imm, ill, n, w0, w1);
    chk({name, "_w0"}, w0, e0);
    if (n == 2) chk({name, "_w1"}, w1, e1);
    else chk({name, "_single"}, 32'(n), 32'd1);
  endtask

  task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic f75,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic ill; int n; logic [31:0] w0, w1; bit acc;
    model_req(k, f3, f75, rd, rs1, rs2, imm, ill, n, w0, w1);
    bus.i_req_kind = k; bus.i_funct3 = f3; bus.i_funct7_5 = f75;
    bus.i_rd = rd; bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm;
    bus.i_req_vld = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (bus.o_req_rdy) begin
        acc = 1'b1;
        if (ill) exp_err++;
        else begin
          exp_q.push_back(w0);
          if (n == 2) exp_q.push_back(w1);
        end
      end
      @(posedge clk); #1;
    end
    bus.i_req_vld = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: kind %0d never accepted", k);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare every held word/address against the model; account for error pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_insn_vld) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_word: got %08h expected none", bus.o_insn);
        end else begin
          chk("insn", bus.o_insn, exp_q[0]);
          chk("pc", bus.o_pc, model_pc);
          if (bus.i_insn_rdy && !flush) begin
            void'(exp_q.pop_front());
            model_pc = model_pc + 32'd4;
          end
        end
      end
      if (bus.o_err) begin
        checks++;
        if (exp_err == 0) begin
          failures++;
          $display("FAIL unexpected_err: got 1 expected 0");
        end else exp_err--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; flush = 1'b0;
    checks = 0; failures = 0; exp_err = 0; model_pc = 32'h0;
    bus.i_req_vld = 1'b0; bus.i_insn_rdy = 1'b1; bus.i_req_kind = 4'd0; bus.i_funct3 = 3'd0;
    bus.i_funct7_5 = 1'b0; bus.i_rd = 5'd0; bus.i_rs1 = 5'd0; bus.i_rs2 = 5'd0; bus.i_imm = 32'd0;
    #1;
    chk("rst_vld", 32'(bus.o_insn_vld), 32'd0);
    chk("rst_insn", bus.o_insn, 32'h0);
    chk("rst_pc", bus.o_pc, 32'h0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_rdy", 32'(bus.o_req_rdy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    idle(1);

    pin("m_add", 4'd0, 32'd0, 5'd3, 1'b0, 32'h0020_81B3, 32'h0);
    pin("m_sub", 4'd0, 32'd0, 5'd3, 1'b1, 32'h4020_81B3, 32'h0);
    pin("m_li1", 4'd9, 32'h1234_5678, 5'd5, 1'b0, 32'h1234_52B7, 32'h6782_8293);
    pin("m_li2", 4'd9, 32'hFFFF_FFFF, 5'd1, 1'b0, 32'hFFF0_0093, 32'h0);
    pin("m_li3", 4'd9, 32'h0000_0800, 5'd6, 1'b0, 32'h0000_1337, 32'h8003_0313);
    pin("m_li4", 4'd9, 32'h0001_0000, 5'd7, 1'b0, 32'h0001_03B7, 32'h0);

    // add / sub with literal pins on the DUT
    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_insn", bus.o_insn, 32'h0020_81B3);
    chk("add_pc", bus.o_pc, 32'h0);
    send(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("sub_insn", bus.o_insn, 32'h4020_81B3);
    chk("sub_pc", bus.o_pc, 32'h4);

    // two-word li stalls requests for one cycle
    send(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    @(negedge clk);
    chk("li_lui", bus.o_insn, 32'h1234_52B7);
    chk("li_stall_rdy", 32'(bus.o_req_rdy), 32'd0);
    @(negedge clk);
    chk("li_addi", bus.o_insn, 32'h6782_8293);
    chk("li_after_rdy", 32'(bus.o_req_rdy), 32'd1);
    @(posedge clk); #1;
    send(4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    send(4'd9, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'h0000_0800);
    send(4'd9, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0001_0000);
    send(4'd9, 3'd0, 1'b0, 5'd8, 5'd0, 5'd0, 32'hFFFF_F800);

    // remaining formats back-to-back
    send(4'd1, 3'd0, 1'b0, 5'd4, 5'd9, 5'd0, 32'hFFFF_FFF6);
    send(4'd1, 3'd5, 1'b1, 5'd4, 5'd9, 5'd0, 32'd7);
    send(4'd1, 3'd1, 1'b0, 5'd4, 5'd9, 5'd0, 32'd31);
    send(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 32'd2044);
    send(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd11, 32'hFFFF_FFFC);
    send(4'd4, 3'd6, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0000_0FFE);
    send(4'd5, 3'd0, 1'b0, 5'd12, 5'd0, 5'd0, 32'hABCD_E123);
    send(4'd6, 3'd0, 1'b0, 5'd13, 5'd0, 5'd0, 32'h0000_1000);
    send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0002);
    send(4'd8, 3'd7, 1'b0, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFF);

    // illegal requests
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    chk("beq_odd_err", 32'(bus.o_err), 32'd1);
    chk("beq_odd_novld", 32'(bus.o_insn_vld), 32'd0);
    send(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0);
    chk("kind12_err", 32'(bus.o_err), 32'd1);
    send(4'd2, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0);
    send(4'd3, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0);
    send(4'd0, 3'd1, 1'b1, 5'd1, 5'd1, 5'd2, 32'd0);
    send(4'd1, 3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1);
    send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle(2);

    // back-pressure: word held, requests stalled, then released
    bus.i_insn_rdy = 1'b0;
    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    fork
      send(4'd0, 3'd7, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_req_rdy", 32'(bus.o_req_rdy), 32'd0);
        end
        @(posedge clk); #1;
        bus.i_insn_rdy = 1'b1;
      end
    join
    send(4'd2, 3'd4, 1'b0, 5'd8, 5'd9, 5'd0, 32'd1);
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16);
    idle(3);

    // flush while the addi half of li is pending
    bus.i_insn_rdy = 1'b0;
    send(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    model_pc = 32'h0;
    chk("flush_vld", 32'(bus.o_insn_vld), 32'd0);
    chk("flush_pc", bus.o_pc, 32'h0);
    bus.i_insn_rdy = 1'b1;
    idle(4);
    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("post_flush_pc", bus.o_pc, 32'h0);
    idle(2);

    // asynchronous reset mid-expansion
    bus.i_insn_rdy = 1'b0;
    send(4'd9, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'h0000_0800);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.o_insn_vld), 32'd0);
    chk("arst_pc", bus.o_pc, 32'h0);
    chk("arst_insn", bus.o_insn, 32'h0);
    chk("arst_rdy", 32'(bus.o_req_rdy), 32'd1);
    exp_q.delete();
    model_pc = 32'h0;
    exp_err = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_insn_rdy = 1'b1;
    idle(3);
    send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    chk("post_rst_pc", bus.o_pc, 32'h0);
    idle(4);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("err_drained", 32'(exp_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
